// File: rtl/dphy_lane_serializer.sv
// MIPI D-PHY data-lane transmit sequencer: LP-11/LP-01/LP-00 entry, HS-zero, sync byte,
// LSB-first payload per lane, trail and LP-11 exit. One HS bit per clock, lanes in lockstep.
module dphy_lane_serializer #(
    parameter int         NUM_LANES = 1,
    parameter int         T_LPX     = 4,
    parameter int         T_PREP    = 4,
    parameter int         T_ZERO    = 8,
    parameter int         T_TRAIL   = 4,
    parameter int         T_EXIT    = 4,
    parameter logic [7:0] SYNC_BYTE = 8'hB8
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic [8*NUM_LANES-1:0] data_i,
    input  logic                   valid_i,
    input  logic                   last_i,
    output logic                   ready_o,
    output logic [NUM_LANES-1:0]   do_p_o,
    output logic [NUM_LANES-1:0]   do_n_o,
    output logic                   busy_o,
    output logic                   underflow_o
);

    localparam int MAX_A  = (T_LPX > T_PREP) ? T_LPX : T_PREP;
    localparam int MAX_B  = (T_ZERO > T_TRAIL) ? T_ZERO : T_TRAIL;
    localparam int MAX_C  = (T_EXIT > 8) ? T_EXIT : 8;
    localparam int MAX_AB = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int MAX_T  = (MAX_AB > MAX_C) ? MAX_AB : MAX_C;
    localparam int CW     = $clog2(MAX_T + 1);

    localparam logic [2:0] ST_STOP  = 3'd0;
    localparam logic [2:0] ST_RQST  = 3'd1;
    localparam logic [2:0] ST_PREP  = 3'd2;
    localparam logic [2:0] ST_ZERO  = 3'd3;
    localparam logic [2:0] ST_SYNC  = 3'd4;
    localparam logic [2:0] ST_DATA  = 3'd5;
    localparam logic [2:0] ST_TRAIL = 3'd6;
    localparam logic [2:0] ST_EXIT  = 3'd7;

    logic [2:0]             state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [8*NUM_LANES-1:0] shift_q, shift_d;
    logic                   last_q, last_d;
    logic [NUM_LANES-1:0]   trail_q, trail_d;
    logic                   bit_last;

    assign bit_last = (cnt_q == CW'(7));

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + CW'(1);
        shift_d     = shift_q;
        last_d      = last_q;
        trail_d     = trail_q;
        ready_o     = 1'b0;
        underflow_o = 1'b0;
        case (state_q)
            ST_STOP: begin
                cnt_d = '0;
                if (valid_i) begin
                    state_d = ST_RQST;
                end
            end
            ST_RQST: begin
                if (cnt_q == CW'(T_LPX - 1)) begin
                    state_d = ST_PREP;
                    cnt_d   = '0;
                end
            end
            ST_PREP: begin
                if (cnt_q == CW'(T_PREP - 1)) begin
                    state_d = ST_ZERO;
                    cnt_d   = '0;
                end
            end
            ST_ZERO: begin
                if (cnt_q == CW'(T_ZERO - 1)) begin
                    state_d = ST_SYNC;
                    cnt_d   = '0;
                end
            end
            ST_SYNC: begin
                if (bit_last) begin
                    ready_o = 1'b1;
                    shift_d = data_i;
                    last_d  = last_i;
                    state_d = ST_DATA;
                    cnt_d   = '0;
                end
            end
            ST_DATA: begin
                for (int k = 0; k < NUM_LANES; k++) begin
                    shift_d[8*k +: 8] = {1'b0, shift_q[8*k+1 +: 7]};
                end
                if (bit_last) begin
                    cnt_d = '0;
                    // Bit 7 is on the line right now; the trail drives its complement.
                    for (int k = 0; k < NUM_LANES; k++) begin
                        trail_d[k] = ~shift_q[8*k];
                    end
                    if (last_q) begin
                        state_d = ST_TRAIL;
                    end else begin
                        ready_o = 1'b1;
                        if (valid_i) begin
                            shift_d = data_i;
                            last_d  = last_i;
                        end else begin
                            underflow_o = 1'b1;
                            state_d     = ST_TRAIL;
                        end
                    end
                end
            end
            ST_TRAIL: begin
                if (cnt_q == CW'(T_TRAIL - 1)) begin
                    state_d = ST_EXIT;
                    cnt_d   = '0;
                end
            end
            ST_EXIT: begin
                if (cnt_q == CW'(T_EXIT - 1)) begin
                    state_d = ST_STOP;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_STOP;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_STOP;
            cnt_q   <= '0;
            shift_q <= '0;
            last_q  <= 1'b0;
            trail_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            last_q  <= last_d;
            trail_q <= trail_d;
        end
    end

    // Line levels depend only on registered state, so the pads never see input glitches.
    always_comb begin
        do_p_o = '1;
        do_n_o = '1;
        case (state_q)
            ST_RQST: begin
                do_p_o = '0;
                do_n_o = '1;
            end
            ST_PREP: begin
                do_p_o = '0;
                do_n_o = '0;
            end
            ST_ZERO: begin
                do_p_o = '0;
                do_n_o = '1;
            end
            ST_SYNC: begin
                do_p_o = {NUM_LANES{SYNC_BYTE[cnt_q[2:0]]}};
                do_n_o = ~do_p_o;
            end
            ST_DATA: begin
                for (int k = 0; k < NUM_LANES; k++) begin
                    do_p_o[k] = shift_q[8*k];
                end
                do_n_o = ~do_p_o;
            end
            ST_TRAIL: begin
                do_p_o = trail_q;
                do_n_o = ~trail_q;
            end
            default: begin
                do_p_o = '1;
                do_n_o = '1;
            end
        endcase
    end

    assign busy_o = (state_q != ST_STOP);

endmodule
